// File: rtl/video_dma_pkg.sv
// Shared definitions for the video capture DMA: AXI encodings, the burst FSM
// state type and the words-per-line helper used to size the burst counter.
package video_dma_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } dma_state_t;

  function automatic int words_per_line(input int img_width, input int bytes_per_pix,
                                        input int bytes_per_word);
    return (img_width * bytes_per_pix) / bytes_per_word;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             empties the FIFO (wins over push)
//   push, push_data   write side
//   pop, pop_data     read side; pop_data shows the head whenever not empty
//   full, empty       status
//   count             number of stored words (0..DEPTH)
module sync_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   pop_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is still accepted when a pop frees a slot this cycle.
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/video_write_dma.sv
// Pixel stream capture into a DDR frame buffer over an AXI4 write master.
// Input beats are packed into bus words, queued in a line FIFO and written as
// fixed-length INCR bursts at line-strided addresses from base_addr.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   base_addr                  frame start address, loaded while vsync is low
//   video_vsync/de/data        active-low frame sync, beat valid, pixels (first in LSBs)
//   axi_aw*, axi_w*, axi_b*    AXI4 write address / data / response channels
//   overflow                   sticky: a packed word was dropped on a full FIFO
//   resp_err                   sticky: a non-OKAY write response was seen
module video_write_dma
  import video_dma_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int AXI_ID_WIDTH   = 8,
  parameter int AXI_ID         = 0,
  parameter int BYTES_PER_PIX  = 4,
  parameter int IMG_WIDTH      = 1920,
  parameter int PIXS_PER_CYC   = 2,
  parameter int IN_WIDTH       = BYTES_PER_PIX * PIXS_PER_CYC * 8,
  parameter int STRIDE         = BYTES_PER_PIX * IMG_WIDTH,
  parameter int BURST_LEN      = 16,
  parameter int FIFO_DEPTH     = 512
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXI_ADDR_WIDTH-1:0]   base_addr,
  input  logic                        video_vsync,
  input  logic                        video_de,
  input  logic [IN_WIDTH-1:0]         video_data,
  output logic [AXI_ID_WIDTH-1:0]     axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]                  axi_awlen,
  output logic [2:0]                  axi_awsize,
  output logic [1:0]                  axi_awburst,
  output logic [1:0]                  axi_awlock,
  output logic                        axi_awvalid,
  input  logic                        axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                        axi_wlast,
  output logic                        axi_wvalid,
  input  logic                        axi_wready,
  input  logic [AXI_ID_WIDTH-1:0]     axi_bid,
  input  logic [1:0]                  axi_bresp,
  input  logic                        axi_bvalid,
  output logic                        axi_bready,
  output logic                        overflow,
  output logic                        resp_err
);

  localparam int BYTES_PER_WORD  = AXI_DATA_WIDTH / 8;
  localparam int SLOTS           = AXI_DATA_WIDTH / IN_WIDTH;
  localparam int SLOT_W          = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int WORDS_PER_LINE  = words_per_line(IMG_WIDTH, BYTES_PER_PIX, BYTES_PER_WORD);
  localparam int BURSTS_PER_LINE = WORDS_PER_LINE / BURST_LEN;
  localparam int BURST_BYTES     = BURST_LEN * BYTES_PER_WORD;
  localparam int CNT_W           = $clog2(FIFO_DEPTH) + 1;

  if (AXI_DATA_WIDTH % IN_WIDTH != 0) begin : g_chk_slots
    $error("AXI_DATA_WIDTH must be a multiple of IN_WIDTH");
  end
  if (WORDS_PER_LINE % BURST_LEN != 0) begin : g_chk_line
    $error("words per line must be a multiple of BURST_LEN");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 2 * BURST_LEN) begin : g_chk_fifo
    $error("FIFO_DEPTH must be a power of two and at least 2*BURST_LEN");
  end

  assign axi_awid    = AXI_ID_WIDTH'(AXI_ID);
  assign axi_awlen   = 8'(BURST_LEN - 1);
  assign axi_awsize  = 3'($clog2(BYTES_PER_WORD));
  assign axi_awburst = BURST_INCR;
  assign axi_awlock  = 2'b00;
  assign axi_wstrb   = '1;
  assign axi_bready  = 1'b1;

  // Responses are only screened for errors; the ID carries no information here.
  logic unused_bid;
  assign unused_bid = ^axi_bid;

  // ---------------- packer ----------------
  logic [SLOT_W-1:0]         slot;
  logic [AXI_DATA_WIDTH-1:0] pack_buf;
  logic [AXI_DATA_WIDTH-1:0] pack_next;
  logic [AXI_DATA_WIDTH-1:0] push_data;
  logic                      push_vld;

  always_comb begin
    pack_next = pack_buf;
    pack_next[slot*IN_WIDTH +: IN_WIDTH] = video_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot     <= '0;
      push_vld <= 1'b0;
    end else begin
      push_vld <= 1'b0;
      if (!video_vsync) begin
        slot <= '0;
      end else if (video_de) begin
        if (slot == SLOT_W'(SLOTS - 1)) begin
          slot     <= '0;
          push_vld <= 1'b1;
        end else begin
          slot <= slot + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (video_vsync && video_de) begin
      pack_buf  <= pack_next;
      push_data <= pack_next;
    end
  end

  // ---------------- FIFO ----------------
  dma_state_t                state;
  logic                      fifo_flush;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty_unused;
  logic [CNT_W-1:0]          fifo_count;
  logic [AXI_DATA_WIDTH-1:0] fifo_head;

  // Flushing only in IDLE lets a burst caught by a frame restart finish cleanly.
  assign fifo_flush = (state == IDLE) && !video_vsync;
  assign fifo_pop   = axi_wvalid && axi_wready;
  assign axi_wdata  = fifo_head;

  sync_fifo #(
    .DATA_WIDTH (AXI_DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (push_vld),
    .push_data (push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty_unused),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      if (push_vld && fifo_full && !fifo_pop && !fifo_flush) overflow <= 1'b1;
      if (axi_bvalid && axi_bready && axi_bresp != RESP_OKAY) resp_err <= 1'b1;
    end
  end

  // ---------------- burst FSM ----------------
  logic [AXI_ADDR_WIDTH-1:0] line_addr;
  logic [AXI_ADDR_WIDTH-1:0] burst_addr;
  logic [15:0]               burst_cnt;
  logic [7:0]                beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      axi_awvalid <= 1'b0;
      axi_awaddr  <= '0;
      axi_wvalid  <= 1'b0;
      axi_wlast   <= 1'b0;
      beat        <= '0;
      burst_cnt   <= '0;
      line_addr   <= '0;
      burst_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!video_vsync) begin
            line_addr  <= base_addr;
            burst_addr <= base_addr;
            burst_cnt  <= '0;
          end else if (fifo_count >= CNT_W'(BURST_LEN)) begin
            state       <= ADDR;
            axi_awvalid <= 1'b1;
            axi_awaddr  <= burst_addr;
          end
        end
        ADDR: begin
          if (axi_awready) begin
            state       <= DATA;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b1;
            axi_wlast   <= (BURST_LEN == 1);
            beat        <= '0;
          end
        end
        DATA: begin
          if (axi_wready) begin
            if (axi_wlast) begin
              state      <= IDLE;
              axi_wvalid <= 1'b0;
              axi_wlast  <= 1'b0;
              if (burst_cnt == 16'(BURSTS_PER_LINE - 1)) begin
                burst_cnt  <= '0;
                line_addr  <= line_addr + AXI_ADDR_WIDTH'(STRIDE);
                burst_addr <= line_addr + AXI_ADDR_WIDTH'(STRIDE);
              end else begin
                burst_cnt  <= burst_cnt + 1'b1;
                burst_addr <= burst_addr + AXI_ADDR_WIDTH'(BURST_BYTES);
              end
            end else begin
              beat      <= beat + 1'b1;
              axi_wlast <= (beat == 8'(BURST_LEN - 2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_write_dma.sv
module tb_video_write_dma;

  localparam int IMG         = 64;
  localparam int BL          = 8;
  localparam int WPL         = 16;   // words per line
  localparam int BPL         = 32;   // input beats per line
  localparam int STRIDE      = 256;
  localparam int BURST_BYTES = 128;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  base_addr;
  logic         video_vsync;
  logic         video_de;
  logic [63:0]  video_data;
  logic [7:0]   axi_awid;
  logic [31:0]  axi_awaddr;
  logic [7:0]   axi_awlen;
  logic [2:0]   axi_awsize;
  logic [1:0]   axi_awburst;
  logic [1:0]   axi_awlock;
  logic         axi_awvalid;
  logic         axi_awready;
  logic [127:0] axi_wdata;
  logic [15:0]  axi_wstrb;
  logic         axi_wlast;
  logic         axi_wvalid;
  logic         axi_wready;
  logic [7:0]   axi_bid;
  logic [1:0]   axi_bresp;
  logic         axi_bvalid;
  logic         axi_bready;
  logic         overflow;
  logic         resp_err;

  always #5 clk = ~clk;

  video_write_dma #(
    .IMG_WIDTH (IMG),
    .BURST_LEN (BL)
  ) dut (
    .clk (clk), .rst (rst), .base_addr (base_addr),
    .video_vsync (video_vsync), .video_de (video_de), .video_data (video_data),
    .axi_awid (axi_awid), .axi_awaddr (axi_awaddr), .axi_awlen (axi_awlen),
    .axi_awsize (axi_awsize), .axi_awburst (axi_awburst), .axi_awlock (axi_awlock),
    .axi_awvalid (axi_awvalid), .axi_awready (axi_awready),
    .axi_wdata (axi_wdata), .axi_wstrb (axi_wstrb), .axi_wlast (axi_wlast),
    .axi_wvalid (axi_wvalid), .axi_wready (axi_wready),
    .axi_bid (axi_bid), .axi_bresp (axi_bresp), .axi_bvalid (axi_bvalid),
    .axi_bready (axi_bready), .overflow (overflow), .resp_err (resp_err)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input string why);
    checks++;
    $display("FAIL %s: %s", name, why);
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0]  exp_aw[$];
  logic [127:0] exp_w[$];
  logic [31:0]  pix[$];
  int           rdy_mode = 0;   // 0: always ready, 1: random stalls, 2: AW blocked
  int           mon_beat = 0;

  initial begin
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       begin axi_awready = 1'b1; axi_wready = 1'b1; end
        1:       begin axi_awready = 1'($urandom_range(1)); axi_wready = 1'($urandom_range(1)); end
        default: begin axi_awready = 1'b0; axi_wready = 1'b1; end
      endcase
    end
  end

  initial begin
    logic         aw_stall = 1'b0;
    logic         w_stall  = 1'b0;
    logic [31:0]  aw_prev;
    logic [127:0] wd_prev;
    logic         wl_prev;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_beat = 0;
        aw_stall = 1'b0;
        w_stall  = 1'b0;
      end else begin
        if (aw_stall) begin
          check("aw_stable_valid", axi_awvalid, 1'b1);
          check("aw_stable_addr", axi_awaddr, aw_prev);
        end
        if (w_stall) begin
          check("w_stable_ctrl", {axi_wvalid, axi_wlast}, {1'b1, wl_prev});
          check("w_stable_data", axi_wdata, wd_prev);
        end
        if (axi_awvalid && axi_awready) begin
          check("aw_fields", {axi_awid, axi_awlen, axi_awsize, axi_awburst, axi_awlock},
                {8'h00, 8'd7, 3'd4, 2'b01, 2'b00});
          if (exp_aw.size() == 0) fail_now("aw_unexpected", $sformatf("addr %h", axi_awaddr));
          else check("awaddr", axi_awaddr, exp_aw.pop_front());
        end
        if (axi_wvalid && axi_wready) begin
          check("wlast", axi_wlast, (mon_beat == BL - 1));
          if (exp_w.size() == 0) fail_now("w_unexpected", $sformatf("data %h", axi_wdata));
          else check("wdata", axi_wdata, exp_w.pop_front());
          mon_beat = (mon_beat + 1) % BL;
        end
        aw_stall = axi_awvalid && !axi_awready;
        aw_prev  = axi_awaddr;
        w_stall  = axi_wvalid && !axi_wready;
        wd_prev  = axi_wdata;
        wl_prev  = axi_wlast;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awvalid"}, axi_awvalid, 1'b0);
    check({tag, "_wvalid"}, axi_wvalid, 1'b0);
    check({tag, "_wlast"}, axi_wlast, 1'b0);
    check({tag, "_awaddr"}, axi_awaddr, 32'h0);
    check({tag, "_overflow"}, overflow, 1'b0);
    check({tag, "_resp_err"}, resp_err, 1'b0);
  endtask

  task automatic frame_start(input logic [31:0] base);
    base_addr   = base;
    video_vsync = 1'b0;
    video_de    = 1'b0;
    repeat (4) tick();
  endtask

  task automatic gen_pixels(input int lines);
    pix.delete();
    for (int i = 0; i < lines * IMG; i++) pix.push_back($urandom);
  endtask

  // Frame-buffer layout: pixel n of a line lives at byte 4*n from the line start.
  task automatic load_expect(input logic [31:0] base, input int lines);
    logic [127:0] w;
    for (int l = 0; l < lines; l++)
      for (int b = 0; b < WPL / BL; b++)
        exp_aw.push_back(base + 32'(l * STRIDE + b * BURST_BYTES));
    for (int n = 0; n < lines * WPL; n++) begin
      for (int p = 0; p < 4; p++) w[32*p +: 32] = pix[4*n + p];
      exp_w.push_back(w);
    end
  endtask

  task automatic stream(input int beats, input bit gaps);
    video_vsync = 1'b1;
    for (int j = 0; j < beats; j++) begin
      while (gaps && $urandom_range(3) == 0) begin
        video_de = 1'b0;
        tick();
      end
      video_de   = 1'b1;
      video_data = {pix[2*j + 1], pix[2*j]};
      tick();
    end
    video_de = 1'b0;
  endtask

  task automatic stream_random(input int beats);
    video_vsync = 1'b1;
    for (int j = 0; j < beats; j++) begin
      video_de   = 1'b1;
      video_data = {$urandom, $urandom};
      tick();
    end
    video_de = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_w.size() != 0 || exp_aw.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) fail_now(name, $sformatf("timeout, %0d words %0d bursts pending", exp_w.size(), exp_aw.size()));
    repeat (4) tick();
  endtask

  task automatic wait_wvalid(input string name);
    int n = 0;
    while (!axi_wvalid && n < 300) begin
      tick();
      n++;
    end
    if (!axi_wvalid) fail_now(name, "wvalid never asserted");
  endtask

  task automatic b_beat(input logic [1:0] resp);
    axi_bvalid = 1'b1;
    axi_bresp  = resp;
    axi_bid    = 8'($urandom);
    tick();
    axi_bvalid = 1'b0;
    axi_bresp  = 2'b00;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int quiet;
    int n;
    rst = 1'b1; base_addr = '0; video_vsync = 1'b0; video_de = 1'b0; video_data = '0;
    axi_bid = '0; axi_bresp = 2'b00; axi_bvalid = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    check("bready_wstrb", {axi_bready, axi_wstrb}, {1'b1, 16'hffff});
    rst = 1'b0;

    // One frame, ready always high.
    rdy_mode = 0;
    frame_start(32'h1000_0000);
    gen_pixels(2);
    load_expect(32'h1000_0000, 2);
    stream(2 * BPL, 1'b1);
    drain("frame1_drain", 2000);
    for (int i = 0; i < 3; i++) b_beat(2'b00);
    tick();
    check("resp_err_okay", resp_err, 1'b0);

    // Same pixels under random AW/W backpressure.
    rdy_mode = 1;
    frame_start(32'h1000_0000);
    load_expect(32'h1000_0000, 2);
    stream(2 * BPL, 1'b1);
    drain("backpressure_drain", 4000);

    // Error response.
    axi_bvalid = 1'b1; axi_bresp = 2'b10; axi_bid = 8'h5a;
    check("resp_err_before", resp_err, 1'b0);
    tick();
    axi_bvalid = 1'b0; axi_bresp = 2'b00;
    check("resp_err_set", resp_err, 1'b1);
    b_beat(2'b00);
    repeat (3) tick();
    check("resp_err_sticky", resp_err, 1'b1);

    // Mid-burst frame restart.
    rdy_mode = 1;
    frame_start(32'h3000_0000);
    gen_pixels(2);
    load_expect(32'h3000_0000, 2);
    stream(2 * BPL, 1'b0);
    wait_wvalid("restart_wvalid");
    video_vsync = 1'b0;
    quiet = 0;
    n = 0;
    while (quiet < 16 && n < 1000) begin
      tick();
      quiet = (!axi_awvalid && !axi_wvalid) ? quiet + 1 : 0;
      n++;
    end
    check("restart_burst_complete", mon_beat, 0);
    exp_aw.delete();
    exp_w.delete();
    frame_start(32'h3800_0000);
    gen_pixels(1);
    load_expect(32'h3800_0000, 1);
    stream(BPL, 1'b1);
    drain("restart_drain", 3000);

    // Reset mid-DATA.
    rdy_mode = 1;
    frame_start(32'h2000_0000);
    gen_pixels(1);
    load_expect(32'h2000_0000, 1);
    stream(BPL, 1'b0);
    wait_wvalid("rst_mid_wvalid");
    rst = 1'b1;
    video_vsync = 1'b0;
    tick();
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    exp_aw.delete();
    exp_w.delete();
    rdy_mode = 0;
    frame_start(32'h4000_0000);
    gen_pixels(1);
    load_expect(32'h4000_0000, 1);
    stream(BPL, 1'b1);
    drain("recovery_drain", 2000);

    // Overflow: AW held off so nothing leaves the FIFO.
    rdy_mode = 2;
    frame_start(32'h5000_0000);
    stream_random(1024);         // exactly 512 words: FIFO full, nothing dropped
    repeat (3) tick();
    check("overflow_at_full", overflow, 1'b0);
    stream_random(2);            // one more word is dropped
    repeat (3) tick();
    check("overflow_set", overflow, 1'b1);
    repeat (1800) tick();
    stream_random(64);
    repeat (3) tick();
    check("overflow_sticky", overflow, 1'b1);
    rst = 1'b1;
    video_vsync = 1'b0;
    repeat (2) tick();
    check_reset_outputs("overflow_rst");
    rst = 1'b0;
    rdy_mode = 0;
    repeat (5) tick();
    check("no_stray_aw", axi_awvalid, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
